reg_write_arbiter: RTL and testbench

- Shares the single write port of the processor's register bank (N independent Register instances, one write enable each) among several requesters: ALU writeback, load unit, I/O input, interrupt/context unit.
- Round-robin arbitration, one grant per cycle, registered outputs.
- Drives a one-hot write enable per register, a common data bus, and a one-cycle grant pulse back to the winning requester.

---
 rtl/reg_write_arbiter.sv | 106 ++++++++++
 tb/tb_reg_write_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port among several requesters.
// One grant per cycle; the just-granted requester is masked for one arbitration.
module reg_write_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NREG  = 8,
    parameter int unsigned AW    = $clog2(NREG)
) (
    input  logic                   local_clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    output logic [NREQ-1:0]        gnt,
    output logic [NREG-1:0]        reg_we,
    output logic [WIDTH-1:0]       reg_d,
    output logic                   busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_n;
    logic [NREQ-1:0]  last_q;
    logic [NREQ-1:0]  last_n;
    logic [NREQ-1:0]  gnt_n;
    logic [NREG-1:0]  we_n;
    logic [WIDTH-1:0] d_n;
    logic [NREQ-1:0]  elig;
    logic [PW:0]      cand;
    logic [PW-1:0]    win;
    logic             found;
    logic [AW-1:0]    addr_sel;
    logic [WIDTH-1:0] data_sel;

    // Rotating search for the first eligible requester at or above ptr.
    always_comb begin
        elig  = req & ~last_q;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!found && elig[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
    end

    // Address and data of the winner.
    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                addr_sel = req_addr[i*AW +: AW];
                data_sel = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for grant, write enable, data bus, pointer and mask.
    always_comb begin
        gnt_n  = '0;
        we_n   = '0;
        d_n    = reg_d;
        ptr_n  = ptr_q;
        last_n = '0;
        if (!stall && found) begin
            gnt_n[win]     = 1'b1;
            we_n[addr_sel] = 1'b1;
            d_n            = data_sel;
            last_n[win]    = 1'b1;
            if (win == PW'(NREQ - 1)) begin
                ptr_n = '0;
            end else begin
                ptr_n = win + PW'(1);
            end
        end
    end

    always_ff @(posedge local_clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            reg_we <= '0;
            reg_d  <= '0;
            ptr_q  <= '0;
            last_q <= '0;
        end else begin
            gnt    <= gnt_n;
            reg_we <= we_n;
            reg_d  <= d_n;
            ptr_q  <= ptr_n;
            last_q <= last_n;
        end
    end

    // Something is waiting that is not being served this cycle.
    assign busy = ~rst & (|(req & ~gnt));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (WIDTH=8, NREQ=4, NREG=8).
module tb_reg_write_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int NREG  = 8;
    localparam int AW    = 3;

    logic                  local_clk = 1'b0;
    logic                  rst;
    logic                  stall;
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREG-1:0]       reg_we;
    logic [WIDTH-1:0]      reg_d;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;

    reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
        .local_clk (local_clk),
        .rst       (rst),
        .stall     (stall),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .gnt       (gnt),
        .reg_we    (reg_we),
        .reg_d     (reg_d),
        .busy      (busy)
    );

    always #5 local_clk = ~local_clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge local_clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_addr[i*AW +: AW]       = a;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic test_reset;
        #1;
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_checks++; if (reg_we !== 8'h00) begin n_fail++; $display("FAIL reset_we: got %b want 00000000", reg_we); end
        n_checks++; if (reg_d !== 8'h00) begin n_fail++; $display("FAIL reset_d: got %h want 00", reg_d); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick;
        rst = 1'b0;
        req = 4'b0010;
        set_src(1, 3'd5, 8'h3C);
        tick;
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL pre_reset_gnt: got %b want 0010", gnt); end
        n_checks++; if (reg_we !== 8'b0010_0000) begin n_fail++; $display("FAIL pre_reset_we: got %b want 00100000", reg_we); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL midreset_gnt: got %b want 0000", gnt); end
        n_checks++; if (reg_we !== 8'h00) begin n_fail++; $display("FAIL midreset_we: got %b want 00000000", reg_we); end
        n_checks++; if (reg_d !== 8'h00) begin n_fail++; $display("FAIL midreset_d: got %h want 00", reg_d); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        req = 4'b0000;
        #1;
        rst = 1'b0;
        tick;
        n_checks++; if (gnt !== 4'b0000 || reg_we !== 8'h00) begin n_fail++; $display("FAIL post_reset_idle: got gnt %b we %b want 0000 00000000", gnt, reg_we); end
        // ptr must be back at 0: with everyone requesting, requester 0 wins
        for (int i = 0; i < NREQ; i++) set_src(i, 3'd0, 8'h00);
        req = 4'b1111;
        tick;
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL post_reset_ptr: got %b want 0001", gnt); end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_single_write;
        req = 4'b0001;
        set_src(0, 3'd3, 8'hA5);
        tick;
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        n_checks++; if (reg_we !== 8'b0000_1000) begin n_fail++; $display("FAIL single_we: got %b want 00001000", reg_we); end
        n_checks++; if (reg_d !== 8'hA5) begin n_fail++; $display("FAIL single_d: got %h want a5", reg_d); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
        req = 4'b0000;
        tick;
        n_checks++; if (gnt !== 4'b0000 || reg_we !== 8'h00) begin n_fail++; $display("FAIL single_drop: got gnt %b we %b want 0000 00000000", gnt, reg_we); end
        n_checks++; if (reg_d !== 8'hA5) begin n_fail++; $display("FAIL single_hold_d: got %h want a5", reg_d); end
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0]  eg;
        logic [NREG-1:0]  ew;
        logic [WIDTH-1:0] ed;
        // grant requester 3 so the pointer returns to 0
        req = 4'b1000;
        set_src(3, 3'd3, 8'h13);
        tick;
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rr_setup: got %b want 1000", gnt); end
        req = 4'b0000;
        tick;
        for (int i = 0; i < NREQ; i++) set_src(i, 3'(i), 8'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            eg = 4'b0001 << (k % 4);
            ew = 8'b0000_0001 << (k % 4);
            ed = 8'(8'h10 + (k % 4));
            n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, eg); end
            n_checks++; if (reg_we !== ew) begin n_fail++; $display("FAIL rr_we[%0d]: got %b want %b", k, reg_we, ew); end
            n_checks++; if (reg_d !== ed) begin n_fail++; $display("FAIL rr_d[%0d]: got %h want %h", k, reg_d, ed); end
        end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_wrap_pointer;
        // ptr is 1 here; granting 2 moves it to 3
        req = 4'b0100;
        tick;
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wrap_g2: got %b want 0100", gnt); end
        req = 4'b0000;
        tick;
        req = 4'b0101;
        tick;
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_g0: got %b want 0001", gnt); end
        tick;
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wrap_next_g2: got %b want 0100", gnt); end
        req = 4'b0000;
        tick;
        // ptr is 3: requester 3 beats requester 1
        req = 4'b1010;
        tick;
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_ptr3: got %b want 1000", gnt); end
        req = 4'b0000;
        tick;
    endtask

    task automatic test_stall;
        req   = 4'b0010;
        stall = 1'b1;
        set_src(1, 3'd6, 8'h5A);
        for (int k = 0; k < 3; k++) begin
            tick;
            n_checks++; if (gnt !== 4'b0000 || reg_we !== 8'h00) begin n_fail++; $display("FAIL stall_out[%0d]: got gnt %b we %b want 0000 00000000", k, gnt, reg_we); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy[%0d]: got %b want 1", k, busy); end
            n_checks++; if (reg_d !== 8'h13) begin n_fail++; $display("FAIL stall_hold_d[%0d]: got %h want 13", k, reg_d); end
        end
        stall = 1'b0;
        tick;
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL unstall_gnt: got %b want 0010", gnt); end
        n_checks++; if (reg_we !== 8'b0100_0000) begin n_fail++; $display("FAIL unstall_we: got %b want 01000000", reg_we); end
        n_checks++; if (reg_d !== 8'h5A) begin n_fail++; $display("FAIL unstall_d: got %h want 5a", reg_d); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL unstall_busy: got %b want 0", busy); end
        // stall arriving during an in-flight write leaves it intact
        stall = 1'b1;
        #2;
        n_checks++; if (reg_we !== 8'b0100_0000) begin n_fail++; $display("FAIL stall_inflight_we: got %b want 01000000", reg_we); end
        tick;
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_block: got gnt %b busy %b want 0000 1", gnt, busy); end
        stall = 1'b0;
        req   = 4'b0000;
        tick;
    endtask

    task automatic test_held_request;
        logic [NREQ-1:0] eg;
        req = 4'b0010;
        set_src(1, 3'd2, 8'h77);
        for (int k = 1; k <= 3; k++) begin
            tick;
            eg = (k == 2) ? 4'b0000 : 4'b0010;
            n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL held_gnt[%0d]: got %b want %b", k, gnt, eg); end
            n_checks++; if ($countones(reg_we) > 1) begin n_fail++; $display("FAIL held_onehot[%0d]: got %b want at most one bit", k, reg_we); end
        end
        req = 4'b0000;
        tick;
        n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL held_end: got %b want 0000", gnt); end
    endtask

    initial begin
        rst      = 1'b1;
        stall    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        test_reset;
        test_single_write;
        test_round_robin;
        test_wrap_pointer;
        test_stall;
        test_held_request;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
